// File: rtl/cam_lookup_param.sv
// rtl/cam_lookup_param.sv - parametrised CAM with lookup/insert/replace/delete and registered results
module cam_lookup_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              init,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  key,
  input  logic [WIDTH-1:0]  new_data,
  output logic              result_valid,
  output logic              hit,
  output logic [ADDR_W-1:0] min_addr,
  output logic [ADDR_W-1:0] max_addr,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow,
  output logic              full,
  output logic              empty
);

  localparam logic [1:0] OP_INSERT  = 2'b01;
  localparam logic [1:0] OP_REPLACE = 2'b10;
  localparam logic [1:0] OP_DELETE  = 2'b11;

  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_d;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] lo_idx;
  logic [ADDR_W-1:0] hi_idx;
  logic [ADDR_W-1:0] free_idx;
  logic [CNT_W-1:0]  cnt;
  logic              any_match;
  logic              has_free;
  logic              do_insert;
  logic              do_replace;
  logic              do_delete;

  // Match on pre-operation contents; also find the lowest free slot.
  always_comb begin
    match    = '0;
    lo_idx   = '0;
    hi_idx   = '0;
    free_idx = '0;
    cnt      = '0;
    has_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (data_q[i] == key);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) lo_idx = ADDR_W'(i);
      if (!valid_q[i]) begin
        free_idx = ADDR_W'(i);
        has_free = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) hi_idx = ADDR_W'(i);
      cnt = cnt + CNT_W'(match[i]);
    end
  end

  assign any_match  = |match;
  assign do_insert  = op_valid && (op == OP_INSERT) && !any_match && has_free;
  assign do_replace = op_valid && (op == OP_REPLACE);
  assign do_delete  = op_valid && (op == OP_DELETE);

  always_comb begin
    valid_d = valid_q;
    if (do_delete) begin
      valid_d = valid_q & ~match;
    end else if (do_insert) begin
      valid_d[free_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      valid_q      <= '0;
      result_valid <= 1'b0;
      hit          <= 1'b0;
      min_addr     <= '0;
      max_addr     <= '0;
      match_count  <= '0;
      overflow     <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
    end else begin
      valid_q      <= valid_d;
      full         <= &valid_d;
      empty        <= ~|valid_d;
      result_valid <= op_valid;
      overflow     <= 1'b0;
      if (op_valid) begin
        hit         <= any_match;
        min_addr    <= lo_idx;
        max_addr    <= hi_idx;
        match_count <= cnt;
        // An insert miss reports the slot it allocated, or overflow when none is free.
        if (op == OP_INSERT && !any_match) begin
          if (has_free) begin
            min_addr <= free_idx;
            max_addr <= free_idx;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      if (do_insert) begin
        data_q[free_idx] <= key;
      end else if (do_replace) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (match[i]) data_q[i] <= new_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_lookup_param.sv
// tb/tb_cam_lookup_param.sv - directed and random checks of cam_lookup_param against a reference model
module tb_cam_lookup_param;
  localparam int WIDTH  = 4;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;
  localparam bit [1:0] LOOKUP = 2'b00, INSERT = 2'b01, REPLACE = 2'b10, DELETE = 2'b11;

  logic              clk = 1'b0;
  logic              init = 1'b1;
  logic              op_valid = 1'b0;
  logic [1:0]        op = 2'b00;
  logic [WIDTH-1:0]  key = '0;
  logic [WIDTH-1:0]  new_data = '0;
  logic              result_valid;
  logic              hit;
  logic [ADDR_W-1:0] min_addr;
  logic [ADDR_W-1:0] max_addr;
  logic [CNT_W-1:0]  match_count;
  logic              overflow;
  logic              full;
  logic              empty;

  int checks = 0;
  int errors = 0;

  bit       m_valid [DEPTH];
  bit [3:0] m_data  [DEPTH];
  bit       e_rv, e_hit, e_ovf;
  int       e_min, e_max, e_cnt;

  always #5 clk = ~clk;

  cam_lookup_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .init(init), .op_valid(op_valid), .op(op), .key(key), .new_data(new_data),
    .result_valid(result_valid), .hit(hit), .min_addr(min_addr), .max_addr(max_addr),
    .match_count(match_count), .overflow(overflow), .full(full), .empty(empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: matches gathered into a queue of indices, results read off it.
  task automatic model(input bit iv, input bit ov, input bit [1:0] o, input bit [3:0] k,
                       input bit [3:0] nd);
    int q[$];
    int fr;
    if (iv) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      e_rv = 0; e_hit = 0; e_min = 0; e_max = 0; e_cnt = 0; e_ovf = 0;
      return;
    end
    e_rv  = ov;
    e_ovf = 0;
    if (!ov) return;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_data[i] == k) q.push_back(i);
    fr = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && fr < 0) fr = i;
    e_hit = (q.size() > 0);
    e_cnt = q.size();
    e_min = (q.size() > 0) ? q[0] : 0;
    e_max = (q.size() > 0) ? q[$] : 0;
    case (o)
      INSERT: if (q.size() == 0) begin
        if (fr >= 0) begin
          m_valid[fr] = 1'b1;
          m_data[fr]  = k;
          e_min = fr;
          e_max = fr;
        end else begin
          e_ovf = 1;
        end
      end
      REPLACE: foreach (q[j]) m_data[q[j]] = nd;
      DELETE:  foreach (q[j]) m_valid[q[j]] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic step(input bit iv, input bit ov, input bit [1:0] o, input bit [3:0] k,
                      input bit [3:0] nd);
    int nv;
    @(negedge clk);
    init = iv; op_valid = ov; op = o; key = k; new_data = nd;
    model(iv, ov, o, k, nd);
    @(posedge clk);
    #1;
    nv = 0;
    foreach (m_valid[i]) nv += int'(m_valid[i]);
    check("result_valid", result_valid, e_rv);
    check("hit", hit, e_hit);
    check("min_addr", min_addr, e_min);
    check("max_addr", max_addr, e_max);
    check("match_count", match_count, e_cnt);
    check("overflow", overflow, e_ovf);
    check("full", full, nv == DEPTH);
    check("empty", empty, nv == 0);
  endtask

  initial begin
    step(1, 0, LOOKUP, 0, 0);
    step(1, 0, LOOKUP, 0, 0);
    check("tp1_empty", empty, 1);
    check("tp1_rv", result_valid, 0);
    step(0, 1, LOOKUP, 4'hB, 0);
    check("tp1_lookup_rv", result_valid, 1);
    check("tp1_lookup_hit", hit, 0);

    step(0, 1, INSERT, 4'hB, 0);
    step(0, 1, INSERT, 4'hE, 0);
    check("tp2_alloc_min", min_addr, 1);
    check("tp2_empty", empty, 0);
    step(0, 1, LOOKUP, 4'hE, 0);
    check("tp2_lookup_hit", hit, 1);
    step(0, 1, INSERT, 4'hB, 0);
    check("tp2_dup_min", min_addr, 0);

    step(0, 1, REPLACE, 4'hE, 4'hB);
    check("tp3_replace_cnt", match_count, 1);
    step(0, 1, LOOKUP, 4'hB, 0);
    check("tp3_cnt", match_count, 2);
    check("tp3_max", max_addr, 1);

    step(1, 0, LOOKUP, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, INSERT, 4'(i), 0);
    check("tp4_full", full, 1);
    step(0, 1, INSERT, 4'hF, 0);
    check("tp4_overflow", overflow, 1);
    step(0, 1, LOOKUP, 4'hF, 0);
    check("tp4_lookup_miss", hit, 0);
    step(0, 1, INSERT, 4'h3, 0);
    check("tp4_hit_min", min_addr, 3);

    step(0, 1, DELETE, 4'h3, 0);
    check("tp5_del_cnt", match_count, 1);
    check("tp5_full", full, 0);
    step(0, 1, LOOKUP, 4'h3, 0);
    step(0, 0, LOOKUP, 0, 0);
    step(0, 1, INSERT, 4'hF, 0);
    check("tp5_alloc", min_addr, 3);

    step(1, 1, INSERT, 4'hA, 0);
    check("tp6_rv", result_valid, 0);
    check("tp6_empty", empty, 1);
    step(0, 1, LOOKUP, 4'hA, 0);
    check("tp6_miss", hit, 0);

    repeat (500) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) step(1, $urandom_range(0, 1), 2'($urandom_range(0, 3)), 0, 0);
      else if (r < 5) step(0, 0, 2'($urandom_range(0, 3)), 4'($urandom), 0);
      else step(0, 1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
